// File: rtl/lbus_master.sv
// lbus_master: command-driven master for a strobed local bus with fixed setup/strobe/recovery timing.
// Define LBUS_MASTER_POLL_EN to compile in the poll op (repeat reads until the masked bits clear).
module lbus_master #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned RECOV_CYC  = 4,
  parameter logic [15:0] POLL_MAX   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] lbus_a,
  output logic [15:0] lbus_di,
  output logic        lbus_wr,
  output logic        lbus_rd,
  input  logic [15:0] lbus_do,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOV, EVAL, RESP} state_t;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [1:0]  op_q;
  logic [15:0] cap;
  logic        accept, legal, phase_done;
  logic        rsp_load, rsp_err_nxt;
  logic [15:0] rsp_data_nxt;
`ifdef LBUS_MASTER_POLL_EN
  logic [15:0] mask, count;
  logic        count_inc;
`else
  logic        unused_poll_max;
  assign unused_poll_max = ^POLL_MAX;
`endif

  function automatic logic last_cyc(input logic [15:0] t, input int unsigned n);
    return t == 16'(n - 1);
  endfunction

`ifdef LBUS_MASTER_POLL_EN
  assign legal = (cmd_op != 2'b11);
`else
  assign legal = (cmd_op == OP_WR) || (cmd_op == OP_RD);
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer + 16'd1;
    accept       = 1'b0;
    phase_done   = 1'b0;
    rsp_load     = 1'b0;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
`ifdef LBUS_MASTER_POLL_EN
    count_inc    = 1'b0;
`endif
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (cmd_valid) begin
          if (legal) begin
            accept    = 1'b1;
            state_nxt = SETUP;
          end else begin
            // Illegal op: answer straight away without touching the bus
            state_nxt   = RESP;
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        phase_done = last_cyc(timer, SETUP_CYC);
        if (phase_done) begin
          state_nxt = STROBE;
          timer_nxt = '0;
        end
      end
      STROBE: begin
        phase_done = last_cyc(timer, STROBE_CYC);
        if (phase_done) begin
          state_nxt = RECOV;
          timer_nxt = '0;
        end
      end
      RECOV: begin
        phase_done = last_cyc(timer, RECOV_CYC);
        if (phase_done) begin
          timer_nxt = '0;
          if (op_q == OP_POLL) begin
            state_nxt = EVAL;
          end else begin
            state_nxt    = RESP;
            rsp_load     = 1'b1;
            rsp_data_nxt = (op_q == OP_RD) ? cap : 16'h0000;
          end
        end
      end
`ifdef LBUS_MASTER_POLL_EN
      EVAL: begin
        timer_nxt = '0;
        if ((cap & mask) == 16'h0000) begin
          state_nxt    = RESP;
          rsp_load     = 1'b1;
          rsp_data_nxt = cap;
        end else begin
          count_inc = 1'b1;
          if (count + 16'd1 == POLL_MAX) begin
            state_nxt    = RESP;
            rsp_load     = 1'b1;
            rsp_data_nxt = cap;
            rsp_err_nxt  = 1'b1;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
`endif
      RESP: begin
        timer_nxt = '0;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      op_q     <= OP_WR;
      lbus_a   <= '0;
      lbus_di  <= '0;
      lbus_wr  <= 1'b0;
      lbus_rd  <= 1'b0;
      cap      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef LBUS_MASTER_POLL_EN
      mask     <= '0;
      count    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      // Strobes are registered so the bus sees glitch-free edges
      lbus_wr <= (state_nxt == STROBE) && (op_q == OP_WR);
      lbus_rd <= (state_nxt == STROBE) && (op_q != OP_WR);
      if (accept) begin
        op_q   <= cmd_op;
        lbus_a <= cmd_addr;
        if (cmd_op == OP_WR) lbus_di <= cmd_data;
`ifdef LBUS_MASTER_POLL_EN
        mask  <= cmd_data;
        count <= '0;
`endif
      end
      if ((state == STROBE) && phase_done) cap <= lbus_do;
`ifdef LBUS_MASTER_POLL_EN
      if (count_inc) count <= count + 16'd1;
`endif
      if (rsp_load) begin
        rsp_data <= rsp_data_nxt;
        rsp_err  <= rsp_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lbus_master.sv
// tb_lbus_master: table-driven bench for lbus_master with a small responder model on the local bus.
module tb_lbus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] lbus_a, lbus_di;
  logic        lbus_wr, lbus_rd;
  logic [15:0] lbus_do;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbus_master #(
    .SETUP_CYC(4), .STROBE_CYC(4), .RECOV_CYC(4), .POLL_MAX(16'd8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr), .lbus_rd(lbus_rd),
    .lbus_do(lbus_do), .busy(busy)
  );

  // Bus monitor: counts strobe pulses and flags any overlap of the two strobes
  int   rd_total = 0;
  int   wr_total = 0;
  logic rd_q = 1'b0;
  logic wr_q = 1'b0;
  bit   overlap = 1'b0;
  always @(posedge clk) begin
    if (lbus_rd && !rd_q) rd_total <= rd_total + 1;
    if (lbus_wr && !wr_q) wr_total <= wr_total + 1;
    rd_q <= lbus_rd;
    wr_q <= lbus_wr;
    if (lbus_wr && lbus_rd) overlap <= 1'b1;
  end

  // Responder: mode 0 returns a constant, mode 1 returns 1 for the first three reads then 0
  bit          resp_mode = 1'b0;
  logic [15:0] resp_val = '0;
  int          rd_base = 0;
  always_comb begin
    if (resp_mode) lbus_do = ((rd_total - rd_base) <= 3) ? 16'h0001 : 16'h0000;
    else           lbus_do = resp_val;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    bit          mode;
    logic [15:0] val;
    int          exp_rd;
    int          exp_wr;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; cycle 1 is the first cycle after accept
  task automatic wait_rsp(input bit chk_bus, input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] data, output int lat, output int first_s,
                          output int last_s, output bit stable_ok, output bit tmo);
    int cyc;
    cyc = 1; first_s = 0; last_s = 0; stable_ok = 1'b1; tmo = 1'b0;
    while (!rsp_valid && cyc < 400) begin
      if (lbus_wr || lbus_rd) begin
        if (first_s == 0) first_s = cyc;
        last_s = cyc;
      end
      if (chk_bus && cyc <= 12 &&
          (lbus_a !== addr || (op == 2'b00 && lbus_di !== data))) stable_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    tmo = !rsp_valid;
    lat = cyc;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, first_s, last_s, rd0, wr0;
    bit stable_ok, tmo, bus;
    logic [15:0] r_data;
    logic        r_err;

    vecs[0] = '{2'b00, 16'h0100, 16'h2B7E, 1'b0, 16'h0000, 0, 1, 16'h0000, 1'b0, 13};
    vecs[1] = '{2'b01, 16'hFFFC, 16'h0000, 1'b0, 16'h4702, 1, 0, 16'h4702, 1'b0, 13};
`ifdef LBUS_MASTER_POLL_EN
    vecs[2] = '{2'b10, 16'h0002, 16'h0001, 1'b1, 16'h0000, 4, 0, 16'h0000, 1'b0, 53};
    vecs[3] = '{2'b10, 16'h0040, 16'h0001, 1'b0, 16'h0003, 8, 0, 16'h0003, 1'b1, 105};
    vecs[4] = '{2'b10, 16'h0080, 16'h0000, 1'b0, 16'hABCD, 1, 0, 16'hABCD, 1'b0, 14};
`else
    vecs[2] = '{2'b10, 16'h0002, 16'h0001, 1'b1, 16'h0000, 0, 0, 16'h0000, 1'b1, 1};
    vecs[3] = '{2'b10, 16'h0040, 16'h0001, 1'b0, 16'h0003, 0, 0, 16'h0000, 1'b1, 1};
    vecs[4] = '{2'b10, 16'h0080, 16'h0000, 1'b0, 16'hABCD, 0, 0, 16'h0000, 1'b1, 1};
`endif
    vecs[5] = '{2'b11, 16'h0300, 16'h5555, 1'b0, 16'h0000, 0, 0, 16'h0000, 1'b1, 1};
    vecs[6] = '{2'b01, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1, 0, 16'h0000, 1'b0, 13};
    vecs[7] = '{2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 0, 1, 16'h0000, 1'b0, 13};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", lbus_wr, 0);
    chk("rst_rd", lbus_rd, 0);
    chk("rst_a", lbus_a, 0);
    chk("rst_di", lbus_di, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Table-driven commands
    for (int i = 0; i < 8; i++) begin
      resp_mode = vecs[i].mode;
      resp_val  = vecs[i].val;
      rd_base   = rd_total;
      rd0 = rd_total; wr0 = wr_total;
      bus = (vecs[i].exp_rd + vecs[i].exp_wr) > 0;
      issue(vecs[i].op, vecs[i].addr, vecs[i].data);
      wait_rsp(bus, vecs[i].op, vecs[i].addr, vecs[i].data, lat, first_s, last_s, stable_ok, tmo);
      r_data = rsp_data; r_err = rsp_err;
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_data", i), r_data, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), r_err, vecs[i].exp_err);
      chk($sformatf("v%0d_rd_strobes", i), rd_total - rd0, vecs[i].exp_rd);
      chk($sformatf("v%0d_wr_strobes", i), wr_total - wr0, vecs[i].exp_wr);
      if (bus) begin
        chk($sformatf("v%0d_addr_stable", i), stable_ok, 1);
        chk($sformatf("v%0d_addr_held", i), lbus_a, vecs[i].addr);
      end
      if (vecs[i].exp_rd + vecs[i].exp_wr == 1) begin
        chk($sformatf("v%0d_strobe_first", i), first_s, 5);
        chk($sformatf("v%0d_strobe_last", i), last_s, 8);
      end
      handshake();
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Reset on the 2nd strobe cycle of a write: abandoned, no response
    resp_mode = 1'b0;
    issue(2'b00, 16'h0100, 16'h2B7E);
    repeat (5) @(posedge clk);
    #1;
    chk("rstw_in_strobe", lbus_wr, 1);
    rst = 1'b1;
    #1;
    chk("rstw_wr", lbus_wr, 0);
    chk("rstw_a", lbus_a, 0);
    chk("rstw_di", lbus_di, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    wr0 = wr_total;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_val = 16'h1357;
    cmd_op = 2'b01; cmd_addr = 16'h0A0A; cmd_data = 16'h0000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rstw_accept_first_edge", busy, 1);
    wait_rsp(1'b1, 2'b01, 16'h0A0A, 16'h0000, lat, first_s, last_s, stable_ok, tmo);
    chk("rstw_timeout", tmo, 0);
    chk("rstw_next_lat", lat, 13);
    chk("rstw_next_data", rsp_data, 16'h1357);
    chk("rstw_next_err", rsp_err, 0);
    chk("rstw_no_wr_restart", wr_total - wr0, 0);
    handshake();

    // Response back-pressure with a new command pending
    resp_val = 16'h5A5A;
    issue(2'b01, 16'h0B00, 16'h0000);
    wait_rsp(1'b1, 2'b01, 16'h0B00, 16'h0000, lat, first_s, last_s, stable_ok, tmo);
    chk("bp_timeout", tmo, 0);
    chk("bp_data", rsp_data, 16'h5A5A);
    wr0 = wr_total; rd0 = rd_total;
    cmd_op = 2'b00; cmd_addr = 16'h0200; cmd_data = 16'h1111; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d_data", k), rsp_data, 16'h5A5A);
      chk($sformatf("bp%0d_err", k), rsp_err, 0);
      chk($sformatf("bp%0d_cmd_ready", k), cmd_ready, 0);
      chk($sformatf("bp%0d_strobes", k), {lbus_wr, lbus_rd}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_idle_after_hs", busy, 0);
    chk("bp_ready_after_hs", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_next_accepted", busy, 1);
    wait_rsp(1'b1, 2'b00, 16'h0200, 16'h1111, lat, first_s, last_s, stable_ok, tmo);
    chk("bp_next_timeout", tmo, 0);
    chk("bp_next_lat", lat, 13);
    chk("bp_next_data", rsp_data, 0);
    chk("bp_next_err", rsp_err, 0);
    chk("bp_next_stable", stable_ok, 1);
    handshake();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_write", wr_total - wr0, 1);
    chk("bp_no_reads", rd_total - rd0, 0);
    chk("bp_still_idle", busy, 0);

    chk("no_strobe_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
